// File: rtl/seconds_timebase_pkg.sv
// -----------------------------------------------------------------------------
// seconds_timebase_pkg
// Shared constants for the seconds timebase: default clock rate, BCD digit
// limits and digit widths.
// -----------------------------------------------------------------------------
package seconds_timebase_pkg;

   localparam int DEFAULT_CLK_HZ = 10_000_000;

   // Largest value each BCD digit may hold
   localparam int ONES_MAX = 9;
   localparam int TENS_MAX = 5;

   // Bit widths of the digit outputs
   localparam int ONES_WIDTH = 4;
   localparam int TENS_WIDTH = 3;

endpackage : seconds_timebase_pkg

// File: rtl/seconds_timebase_bcd_digit_counter.sv
// -----------------------------------------------------------------------------
// bcd_digit_counter
// One modulo-N decimal digit. Counts 0..MODULUS-1 on inc, rolls over to 0.
//
// Ports:
//   clk   in   clock, rising edge
//   rst   in   asynchronous active-high reset, digit -> 0
//   inc   in   advance the digit by one this cycle
//   clr   in   synchronous clear, wins over inc
//   digit out  current digit value
//   carry out  combinational, high when inc and digit is at its maximum
// -----------------------------------------------------------------------------
module bcd_digit_counter
   import seconds_timebase_pkg::*;
#(
   parameter int MODULUS = 10,
   parameter int WIDTH   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] digit,
   output logic             carry
);

   localparam logic [WIDTH-1:0] DIGIT_MAX = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] r_digit;
   logic             w_at_max;

   assign w_at_max = (r_digit == DIGIT_MAX);
   // Carry is combinational so the next digit advances on the same edge
   assign carry    = inc & w_at_max;
   assign digit    = r_digit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_digit <= '0;
      end else if (clr) begin
         r_digit <= '0;
      end else if (inc) begin
         r_digit <= w_at_max ? '0 : r_digit + 1'b1;
      end
   end

endmodule : bcd_digit_counter

// File: rtl/seconds_timebase.sv
// -----------------------------------------------------------------------------
// seconds_timebase
// Programmable prescaler feeding a two-digit BCD seconds counter (00..59).
// The prescaler counts 0..compare; on reaching compare it restarts and the
// digits advance, with single-cycle tick (and wrap on 59->00) strobes.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   ena        in   design enable, low freezes all state
//   run        in   count enable, low pauses prescaler and digits
//   clear      in   synchronous clear of prescaler and digits
//   cmp_load   in   load cmp_value into compare register, restart prescaler
//   cmp_value  in   new period minus one
//   ones       out  BCD ones digit 0..9
//   tens       out  BCD tens digit 0..5
//   tick       out  one-cycle pulse, same cycle the new digits appear
//   wrap       out  one-cycle pulse with tick on 59->00
// -----------------------------------------------------------------------------
module seconds_timebase
   import seconds_timebase_pkg::*;
#(
   parameter int CLK_HZ    = DEFAULT_CLK_HZ,
   parameter int CMP_WIDTH = 24
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ena,
   input  logic                  run,
   input  logic                  clear,
   input  logic                  cmp_load,
   input  logic [CMP_WIDTH-1:0]  cmp_value,
   output logic [ONES_WIDTH-1:0] ones,
   output logic [TENS_WIDTH-1:0] tens,
   output logic                  tick,
   output logic                  wrap
);

   localparam logic [CMP_WIDTH-1:0] CMP_RESET = CMP_WIDTH'(CLK_HZ - 1);

   logic [CMP_WIDTH-1:0] r_presc;
   logic [CMP_WIDTH-1:0] r_cmp;
   logic                 r_tick;
   logic                 r_wrap;

   logic w_terminal;
   logic w_ctrl;
   logic w_advance;
   logic w_dig_clr;
   logic w_ones_carry;
   logic w_tens_carry;

   assign w_terminal = (r_presc == r_cmp);
   // clear/cmp_load both restart the prescaler and suppress counting
   assign w_ctrl     = clear | cmp_load;
   assign w_advance  = ena & run & ~w_ctrl & w_terminal;
   assign w_dig_clr  = ena & clear;

   bcd_digit_counter #(
      .MODULUS (ONES_MAX + 1),
      .WIDTH   (ONES_WIDTH)
   ) u_ones (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_advance),
      .clr   (w_dig_clr),
      .digit (ones),
      .carry (w_ones_carry)
   );

   bcd_digit_counter #(
      .MODULUS (TENS_MAX + 1),
      .WIDTH   (TENS_WIDTH)
   ) u_tens (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_ones_carry),
      .clr   (w_dig_clr),
      .digit (tens),
      .carry (w_tens_carry)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_presc <= '0;
         r_cmp   <= CMP_RESET;
         r_tick  <= 1'b0;
         r_wrap  <= 1'b0;
      end else if (!ena) begin
         // Everything holds; strobes are forced low
         r_tick  <= 1'b0;
         r_wrap  <= 1'b0;
      end else if (w_ctrl) begin
         r_presc <= '0;
         if (cmp_load) begin
            r_cmp <= cmp_value;
         end
         r_tick  <= 1'b0;
         r_wrap  <= 1'b0;
      end else if (run) begin
         if (w_terminal) begin
            r_presc <= '0;
            r_tick  <= 1'b1;
            r_wrap  <= w_tens_carry;
         end else begin
            r_presc <= r_presc + 1'b1;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
         end
      end else begin
         r_tick  <= 1'b0;
         r_wrap  <= 1'b0;
      end
   end

   assign tick = r_tick;
   assign wrap = r_wrap;

endmodule : seconds_timebase

// File: tb/tb_seconds_timebase.sv
module tb_seconds_timebase;

  localparam int CLK_HZ = 200;
  localparam int CW     = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          ena;
  logic          run;
  logic          clear;
  logic          cmp_load;
  logic [CW-1:0] cmp_value;
  logic [3:0]    ones;
  logic [2:0]    tens;
  logic          tick;
  logic          wrap;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: elapsed seconds as a plain integer 0..59, prescaler
  // phase and period as integers.
  int m_phase;
  int m_period_m1;
  int m_secs;
  bit m_tick;
  bit m_wrap;

  seconds_timebase #(
    .CLK_HZ    (CLK_HZ),
    .CMP_WIDTH (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .run       (run),
    .clear     (clear),
    .cmp_load  (cmp_load),
    .cmp_value (cmp_value),
    .ones      (ones),
    .tens      (tens),
    .tick      (tick),
    .wrap      (wrap)
  );

  // clock/reset block
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase     = 0;
    m_period_m1 = CLK_HZ - 1;
    m_secs      = 0;
    m_tick      = 0;
    m_wrap      = 0;
  endtask

  // One clock edge of the reference behaviour, from the current inputs
  task automatic model_edge();
    m_tick = 0;
    m_wrap = 0;
    if (rst) begin
      model_reset();
    end else if (ena) begin
      if (clear || cmp_load) begin
        if (cmp_load) m_period_m1 = int'(cmp_value);
        if (clear) m_secs = 0;
        m_phase = 0;
      end else if (run) begin
        if (m_phase == m_period_m1) begin
          m_phase = 0;
          m_secs  = (m_secs + 1) % 60;
          m_tick  = 1;
          m_wrap  = (m_secs == 0);
        end else begin
          m_phase++;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":ones"}, 8'(ones), 8'(m_secs % 10));
    chk({tag, ":tens"}, 8'(tens), 8'(m_secs / 10));
    chk({tag, ":tick"}, 8'(tick), 8'(m_tick));
    chk({tag, ":wrap"}, 8'(wrap), 8'(m_wrap));
  endtask

  // driver: apply current inputs across one edge, then check at edge+1
  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic steps(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic load(input int v, input bit do_clear, input string tag);
    cmp_load  = 1'b1;
    cmp_value = CW'(v);
    clear     = do_clear;
    step(tag);
    cmp_load  = 1'b0;
    clear     = 1'b0;
  endtask

  int ticks;
  int wraps;

  initial begin
    rst = 1'b1; ena = 1'b0; run = 1'b0; clear = 1'b0;
    cmp_load = 1'b0; cmp_value = '0;
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;
    ena = 1'b1;

    // Async reset mid-count at 37
    load(0, 1'b1, "pre37");
    run = 1'b1;
    steps(37, "to37");
    chk("at37_ones", 8'(ones), 8'd7);
    chk("at37_tens", 8'(tens), 8'd3);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    step("rst_hold");
    rst = 1'b0;
    ticks = 0;
    for (int i = 0; i < CLK_HZ - 1; i++) begin
      step("default_period");
      if (tick) ticks++;
    end
    chk("no_early_tick", 8'(ticks), 8'd0);
    step("default_first_tick");
    chk("default_tick", 8'(tick), 8'd1);

    // Programmed period of 4 cycles
    load(3, 1'b1, "load3");
    ticks = 0;
    for (int i = 0; i < 40; i++) begin
      step("period4");
      if (tick) ticks++;
    end
    chk("period4_ticks", 8'(ticks), 8'd10);
    chk("period4_ones", 8'(ones), 8'd0);
    chk("period4_tens", 8'(tens), 8'd1);

    // Wrap at compare 0
    load(0, 1'b1, "load0");
    wraps = 0;
    for (int i = 0; i < 59; i++) begin
      step("wrap_run");
      if (wrap) wraps++;
    end
    chk("at59_ones", 8'(ones), 8'd9);
    chk("at59_tens", 8'(tens), 8'd5);
    step("wrap_edge");
    chk("wrap_strobe", 8'(wrap), 8'd1);
    chk("wrap_tick", 8'(tick), 8'd1);
    chk("wraps_before", 8'(wraps), 8'd0);
    step("after_wrap");
    chk("wrap_single", 8'(wrap), 8'd0);

    // Pause with run
    load(3, 1'b1, "pause_load");
    steps(2, "pause_pre");
    run = 1'b0;
    steps(10, "paused");
    run = 1'b1;
    step("resume1");
    chk("resume1_tick", 8'(tick), 8'd0);
    step("resume2");
    chk("resume2_tick", 8'(tick), 8'd1);

    // Hold with ena=0 and an ignored clear
    load(3, 1'b1, "ena_load");
    steps(6, "ena_pre");
    ena = 1'b0;
    clear = 1'b1;
    steps(10, "ena_hold");
    chk("ena_hold_ones", 8'(ones), 8'd1);
    clear = 1'b0;
    ena = 1'b1;
    step("ena_resume1");
    step("ena_resume2");
    chk("ena_resume_tick", 8'(tick), 8'd1);
    chk("ena_resume_ones", 8'(ones), 8'd2);

    // Clear + load at terminal count with digits at 42
    load(3, 1'b1, "sim_load");
    steps(4 * 42 + 3, "to42");
    chk("at42_ones", 8'(ones), 8'd2);
    chk("at42_tens", 8'(tens), 8'd4);
    load(1, 1'b1, "sim_ctrl");
    chk("sim_no_tick", 8'(tick), 8'd0);
    chk("sim_ones0", 8'(ones), 8'd0);
    step("sim_after1");
    step("sim_after2");
    chk("sim_next_tick", 8'(tick), 8'd1);

    // Load on the terminal cycle suppresses the tick
    load(3, 1'b1, "sup_load");
    steps(7, "sup_pre");
    load(5, 1'b0, "sup_ctrl");
    chk("sup_no_tick", 8'(tick), 8'd0);
    chk("sup_ones", 8'(ones), 8'd1);
    ticks = 0;
    for (int i = 0; i < 5; i++) begin
      step("sup_wait");
      if (tick) ticks++;
    end
    chk("sup_quiet", 8'(ticks), 8'd0);
    step("sup_tick");
    chk("sup_next_tick", 8'(tick), 8'd1);

    // Randomized traffic against the model
    load(2, 1'b1, "rand_load");
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 499) == 0);
      ena       = ($urandom_range(0, 9) != 0);
      run       = ($urandom_range(0, 7) != 0);
      clear     = ($urandom_range(0, 59) == 0);
      cmp_load  = ($urandom_range(0, 49) == 0);
      cmp_value = CW'($urandom_range(0, 6));
      step("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_seconds_timebase
